// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared constants for the sound frame sequencer and its neighbours.
//   VOL_W / DAT_W / SUM_W : widths of the mulacc volume, sample and sum buses
//   MULACC_LAT            : clocks from a LOAD cycle until the mulacc raises
//                           ready (timeout reference for benches only)
//   IDLE..STORE           : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package sound_pkg;

    localparam int VOL_W      = 6;
    localparam int DAT_W      = 8;
    localparam int SUM_W      = 16;
    localparam int MULACC_LAT = 17;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t GUARD = 3'd2;
    localparam state_t WAIT  = 3'd3;
    localparam state_t STORE = 3'd4;

endpackage

// File: rtl/sound_mulacc_seq_if.sv
// ---------------------------------------------------------------------------
// sound_mulacc_seq_if
// Bus between the frame sequencer and the sound_mulacc serial MAC.
//   mac_vol     : channel volume (unsigned)        sequencer -> mulacc
//   mac_dat     : channel sample byte              sequencer -> mulacc
//   mac_inv7b   : bit-7 inversion mode             sequencer -> mulacc
//   mac_load    : one-clock start of a multiply    sequencer -> mulacc
//   mac_clr_sum : restart the accumulator on load  sequencer -> mulacc
//   mac_ready   : result available                 mulacc -> sequencer
//   mac_sum     : running accumulator              mulacc -> sequencer
// Modports: master = sequencer side, slave = mulacc side.
// ---------------------------------------------------------------------------
interface sound_mulacc_seq_if;
    import sound_pkg::*;

    logic [VOL_W-1:0] mac_vol;
    logic [DAT_W-1:0] mac_dat;
    logic             mac_inv7b;
    logic             mac_load;
    logic             mac_clr_sum;
    logic             mac_ready;
    logic [SUM_W-1:0] mac_sum;

    modport master (
        output mac_vol, mac_dat, mac_inv7b, mac_load, mac_clr_sum,
        input  mac_ready, mac_sum
    );

    modport slave (
        input  mac_vol, mac_dat, mac_inv7b, mac_load, mac_clr_sum,
        output mac_ready, mac_sum
    );

endinterface

// File: rtl/sound_mulacc_seq.sv
// ---------------------------------------------------------------------------
// sound_mulacc_seq
// Frame sequencer time-sharing one sound_mulacc across NUM_CH channels.
// On each start tick it walks channels 0..NUM_CH-1, presents each channel's
// volume/sample to the mulacc, pulses load and waits for ready. Channels in
// the lower half accumulate into the left sum, the upper half into the right.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-clock sample tick that begins a frame
//   mode_inv7b   : global bit-7 inversion mode forwarded to the mulacc
//   ch_en        : per-channel enable (disabled channel uses volume 0)
//   ch_sel       : channel currently addressed in the register file
//   ch_vol/ch_dat: combinational read data for ch_sel
//   mac          : mulacc bus (master side)
//   out_l/out_r  : latched left/right frame sums
//   frame_done   : one-clock pulse when out_l/out_r have been updated
//   busy         : frame in progress
//   overrun      : sticky, start seen while a frame was in progress
// ---------------------------------------------------------------------------
module sound_mulacc_seq
    import sound_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CW     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_inv7b,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic [CW-1:0]        ch_sel,
    input  logic [VOL_W-1:0]     ch_vol,
    input  logic [DAT_W-1:0]     ch_dat,
    sound_mulacc_seq_if.master   mac,
    output logic [SUM_W-1:0]     out_l,
    output logic [SUM_W-1:0]     out_r,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [CW-1:0] RIGHT_FIRST = CW'(NUM_CH / 2);
    localparam logic [CW-1:0] LEFT_LAST   = CW'(NUM_CH / 2 - 1);
    localparam logic [CW-1:0] LAST_SEL    = CW'(NUM_CH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    sel_q, sel_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             inv_q, inv_d;
    logic             load_q, load_d;
    logic             clr_q, clr_d;
    logic [SUM_W-1:0] out_l_q, out_l_d;
    logic [SUM_W-1:0] out_r_q, out_r_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            vol_q     <= '0;
            dat_q     <= '0;
            inv_q     <= 1'b0;
            load_q    <= 1'b0;
            clr_q     <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            vol_q     <= vol_d;
            dat_q     <= dat_d;
            inv_q     <= inv_d;
            load_q    <= load_d;
            clr_q     <= clr_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = GUARD;
            // mac_load is high during GUARD, so ready still shows the previous
            // channel's result here; the mulacc drops it on this cycle's edge.
            GUARD:   state_d = WAIT;
            WAIT:    if (mac.mac_ready) state_d = (sel_q == LAST_SEL) ? STORE : LOAD;
            STORE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        sel_d     = sel_q;
        vol_d     = vol_q;
        dat_d     = dat_q;
        inv_d     = inv_q;
        load_d    = 1'b0;
        clr_d     = 1'b0;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        // Any start outside IDLE (STORE included) is an overrun.
        overrun_d = overrun_q | (start && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d  = '0;
                    busy_d = 1'b1;
                end
            end
            LOAD: begin
                load_d = 1'b1;
                vol_d  = ch_en[sel_q] ? ch_vol : '0;
                dat_d  = ch_dat;
                inv_d  = mode_inv7b;
                // Each half starts a fresh accumulation on its first channel.
                clr_d  = (sel_q == '0) || (sel_q == RIGHT_FIRST);
            end
            WAIT: begin
                if (mac.mac_ready) begin
                    if (sel_q == LEFT_LAST) begin
                        out_l_d = mac.mac_sum;
                    end
                    if (sel_q == LAST_SEL) begin
                        // Right sum lands together with frame_done in STORE.
                        out_r_d = mac.mac_sum;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        sel_d = sel_q + CW'(1);
                    end
                end
            end
            STORE: begin
                sel_d = '0;
            end
            default: ;
        endcase
    end

    assign ch_sel          = sel_q;
    assign mac.mac_vol     = vol_q;
    assign mac.mac_dat     = dat_q;
    assign mac.mac_inv7b   = inv_q;
    assign mac.mac_load    = load_q;
    assign mac.mac_clr_sum = clr_q;
    assign out_l           = out_l_q;
    assign out_r           = out_r_q;
    assign frame_done      = done_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sound_mulacc_seq.sv
// ---------------------------------------------------------------------------
// tb_sound_mulacc_seq
// Bench for the frame sequencer: behavioural channel RAM and behavioural
// sound_mulacc beside the DUT, table-driven frames, random frames against a
// plain-arithmetic reference, and hand-written overrun/reset/back-to-back
// sequences.
// ---------------------------------------------------------------------------
module tb_sound_mulacc_seq;
    import sound_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int CW        = 3;
    localparam int FRAME_CYC = NUM_CH * (MULACC_LAT + 1) + 1;
    localparam int BUDGET    = FRAME_CYC + 14;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              mode_inv7b = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [CW-1:0]     ch_sel;
    logic [VOL_W-1:0]  ch_vol;
    logic [DAT_W-1:0]  ch_dat;
    logic [SUM_W-1:0]  out_l, out_r;
    logic              frame_done, busy, overrun;

    sound_mulacc_seq_if mac_bus ();

    sound_mulacc_seq #(.NUM_CH(NUM_CH), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode_inv7b (mode_inv7b),
        .ch_en      (ch_en),
        .ch_sel     (ch_sel),
        .ch_vol     (ch_vol),
        .ch_dat     (ch_dat),
        .mac        (mac_bus),
        .out_l      (out_l),
        .out_r      (out_r),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Channel register file
    logic [VOL_W-1:0] vol_mem [NUM_CH];
    logic [DAT_W-1:0] dat_mem [NUM_CH];
    assign ch_vol = vol_mem[ch_sel];
    assign ch_dat = dat_mem[ch_sel];

    // Behavioural mulacc: samples load on the edge ending GUARD, ready returns
    // MULACC_LAT clocks after the LOAD cycle began. Not reset, like the real one.
    logic [SUM_W-1:0] m_acc = '0;
    logic [SUM_W-1:0] m_sum = '0;
    logic             m_ready = 1'b1;
    int               m_cnt = 0;
    assign mac_bus.mac_ready = m_ready;
    assign mac_bus.mac_sum   = m_sum;

    function automatic logic [SUM_W-1:0] mul(input logic [VOL_W-1:0] v,
                                             input logic [DAT_W-1:0] d,
                                             input logic inv);
        logic [7:0] b;
        int sv;
        b  = inv ? d : (d ^ 8'h80);
        sv = int'($signed(b));
        return SUM_W'(sv * int'(v));
    endfunction

    always @(posedge clock) begin
        if (mac_bus.mac_load) begin
            m_acc   <= (mac_bus.mac_clr_sum ? '0 : m_acc)
                       + mul(mac_bus.mac_vol, mac_bus.mac_dat, mac_bus.mac_inv7b);
            m_ready <= 1'b0;
            m_cnt   <= MULACC_LAT - 2;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_sum   <= m_acc;
            end
        end
    end

    // Load-pulse monitor
    int         cyc = 0;
    int         load_cnt, last_load, min_gap;
    logic [7:0] clr_mask;
    always @(posedge clock) cyc = cyc + 1;
    always @(negedge clock) begin
        if (mac_bus.mac_load) begin
            load_cnt = load_cnt + 1;
            if (mac_bus.mac_clr_sum) clr_mask[ch_sel] = 1'b1;
            if (last_load >= 0 && (cyc - last_load) < min_gap) min_gap = cyc - last_load;
            last_load = cyc;
        end
    end

    // Reference: per-half sum of volume * signed sample, 16-bit wrap
    function automatic logic [31:0] ref_sums(input logic [NUM_CH-1:0] en, input logic inv);
        int l = 0;
        int r = 0;
        int s, p;
        for (int i = 0; i < NUM_CH; i++) begin
            s = inv ? int'($signed(dat_mem[i])) : int'(dat_mem[i]) - 128;
            p = en[i] ? int'(vol_mem[i]) * s : 0;
            if (i < NUM_CH / 2) l += p;
            else                r += p;
        end
        return {r[15:0], l[15:0]};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int n_done, first_done, last_done;
    logic busy_first;

    // Pulse start (cycle 0), then observe cycles 1..ncyc; optional second
    // start pulse driven during cycle start2_at.
    task automatic run_frame(input int start2_at, input int ncyc);
        load_cnt = 0; clr_mask = '0; last_load = -1; min_gap = 1000;
        n_done = 0; first_done = -1; last_done = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_first = busy;
        for (int k = 1; k <= ncyc; k++) begin
            if (frame_done) begin
                n_done++;
                if (first_done < 0) first_done = k;
                last_done = k;
            end
            start = (k == start2_at);
            tick();
        end
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [NUM_CH-1:0][VOL_W-1:0] vol;
        logic [NUM_CH-1:0][DAT_W-1:0] dat;
        logic [NUM_CH-1:0]            en;
        logic                         inv;
        logic [SUM_W-1:0]             exp_l;
        logic [SUM_W-1:0]             exp_r;
    } vec_t;

    vec_t tbl [4];

    task automatic apply_vec(input vec_t v);
        for (int i = 0; i < NUM_CH; i++) begin
            vol_mem[i] = v.vol[i];
            dat_mem[i] = v.dat[i];
        end
        ch_en      = v.en;
        mode_inv7b = v.inv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;

        tbl[0] = '{vol: {8{6'd63}}, dat: {{4{8'h00}}, {4{8'hFF}}}, en: 8'hFF, inv: 1'b0,
                   exp_l: 16'h7D04, exp_r: 16'h8200};
        tbl[1] = '{vol: {8{6'd63}}, dat: {{4{8'h00}}, {4{8'hFF}}}, en: 8'hFE, inv: 1'b0,
                   exp_l: 16'h5DC3, exp_r: 16'h8200};
        tbl[2] = '{vol: {8{6'd63}}, dat: {{4{8'h00}}, {4{8'hFF}}}, en: 8'h00, inv: 1'b0,
                   exp_l: 16'h0000, exp_r: 16'h0000};
        tbl[3] = '{vol: {{4{6'd10}}, {4{6'd63}}}, dat: {{4{8'h80}}, {4{8'h7F}}}, en: 8'hFF,
                   inv: 1'b1, exp_l: 16'h7D04, exp_r: 16'hEC00};
        apply_vec(tbl[0]);

        do_reset();
        check("rst_ch_sel", 32'(ch_sel), 0);
        check("rst_mac_load", 32'(mac_bus.mac_load), 0);
        check("rst_mac_clr", 32'(mac_bus.mac_clr_sum), 0);
        check("rst_mac_vol", 32'(mac_bus.mac_vol), 0);
        check("rst_mac_dat", 32'(mac_bus.mac_dat), 0);
        check("rst_mac_inv", 32'(mac_bus.mac_inv7b), 0);
        check("rst_out_l", 32'(out_l), 0);
        check("rst_out_r", 32'(out_r), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);

        for (int v = 0; v < 4; v++) begin
            apply_vec(tbl[v]);
            run_frame(-1, BUDGET);
            check($sformatf("vec%0d_out_l", v), 32'(out_l), 32'(tbl[v].exp_l));
            check($sformatf("vec%0d_out_r", v), 32'(out_r), 32'(tbl[v].exp_r));
            check($sformatf("vec%0d_done_cycle", v), first_done, FRAME_CYC);
            check($sformatf("vec%0d_done_count", v), n_done, 1);
            check($sformatf("vec%0d_load_count", v), load_cnt, NUM_CH);
            check($sformatf("vec%0d_clr_mask", v), 32'(clr_mask), 32'h11);
            check($sformatf("vec%0d_load_gap", v), 32'(min_gap >= MULACC_LAT + 1), 1);
            check($sformatf("vec%0d_busy_start", v), 32'(busy_first), 1);
            check($sformatf("vec%0d_busy_end", v), 32'(busy), 0);
            check($sformatf("vec%0d_overrun", v), 32'(overrun), 0);
        end

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                vol_mem[i] = 6'($urandom_range(0, 63));
                dat_mem[i] = 8'($urandom);
            end
            ch_en      = 8'($urandom);
            mode_inv7b = 1'($urandom);
            exp = ref_sums(ch_en, mode_inv7b);
            run_frame(-1, BUDGET);
            check($sformatf("rand%0d_out_l", t), 32'(out_l), 32'(exp[15:0]));
            check($sformatf("rand%0d_out_r", t), 32'(out_r), 32'(exp[31:16]));
            check($sformatf("rand%0d_done_cycle", t), first_done, FRAME_CYC);
        end

        // start coinciding with the frame_done cycle is an overrun, not a frame
        apply_vec(tbl[0]);
        run_frame(FRAME_CYC, BUDGET);
        check("store_start_overrun", 32'(overrun), 1);
        check("store_start_done_count", n_done, 1);
        check("store_start_load_count", load_cnt, NUM_CH);
        check("store_start_busy_end", 32'(busy), 0);

        do_reset();
        check("overrun_cleared", 32'(overrun), 0);

        // start mid-frame
        run_frame(50, BUDGET);
        check("mid_start_overrun", 32'(overrun), 1);
        check("mid_start_done_cycle", first_done, FRAME_CYC);
        check("mid_start_done_count", n_done, 1);
        check("mid_start_out_l", 32'(out_l), 32'h7D04);
        check("mid_start_out_r", 32'(out_r), 32'h8200);
        for (int k = 0; k < 10; k++) tick();
        check("overrun_sticky", 32'(overrun), 1);

        // reset at cycle 70 of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 70; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_l", 32'(out_l), 0);
        check("midrst_out_r", 32'(out_r), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_ch_sel", 32'(ch_sel), 0);
        check("midrst_mac_vol", 32'(mac_bus.mac_vol), 0);
        check("midrst_mac_dat", 32'(mac_bus.mac_dat), 0);
        for (int k = 0; k < 3; k++) tick();
        check("midrst_idle_load", 32'(mac_bus.mac_load), 0);
        check("midrst_idle_busy", 32'(busy), 0);
        run_frame(-1, BUDGET);
        check("after_rst_out_l", 32'(out_l), 32'h7D04);
        check("after_rst_out_r", 32'(out_r), 32'h8200);
        check("after_rst_done_cycle", first_done, FRAME_CYC);

        // back-to-back: second start on the cycle after frame_done
        apply_vec(tbl[3]);
        run_frame(FRAME_CYC + 1, 2 * FRAME_CYC + 10);
        check("b2b_done_count", n_done, 2);
        check("b2b_first_done", first_done, FRAME_CYC);
        check("b2b_second_done", last_done, 2 * FRAME_CYC + 1);
        check("b2b_overrun", 32'(overrun), 0);
        check("b2b_load_count", load_cnt, 2 * NUM_CH);
        check("b2b_out_l", 32'(out_l), 32'(tbl[3].exp_l));
        check("b2b_out_r", 32'(out_r), 32'(tbl[3].exp_r));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
